// File: rtl/polaris_bus_pkg.sv
// Shared types and constants for the Polaris I/D memory-port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package polaris_bus_pkg;

    // Grant state; IDLE drives nothing onto the memory port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    // Instruction fetches are always full 32-bit words.
    localparam logic [1:0] SIZ_WORD = 2'b10;

    // Pick the 32-bit half of a 64-bit beat addressed by bit 2.
    function automatic logic [31:0] word_sel(input logic [63:0] dat, input logic hi);
        return hi ? dat[63:32] : dat[31:0];
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall counter for a granted strobe; flags expiry once TIMEOUT stalled cycles have elapsed.
// Latency: expired_o is a registered compare, valid the cycle after the last counted stall.
// Backpressure: none; the counter saturates at TIMEOUT, and TIMEOUT=0 keeps it parked at zero.
module bus_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_cnt_en,
    output logic o_expired
);

    localparam logic [CNTW-1:0] LIMIT = CNTW'(TIMEOUT);

    logic [CNTW-1:0] r_cnt;

    // Count stalled strobe cycles, clearing on demand and holding at the limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/polaris_bus_arbiter.sv
// Shares one 64-bit memory port between the CPU instruction (I) and data (D) masters.
// Latency: request sampled at edge n drives mstb_o in cycle n+1; acks/data return combinationally.
// Backpressure: the ungranted master simply waits; D keeps the bus while dcyc_i is high; a watchdog aborts stalled strobes.
module polaris_bus_arbiter
    import polaris_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        istb_i,
    input  logic [63:0] iadr_i,
    output logic [31:0] idat_o,
    output logic        iack_o,
    output logic        ierr_o,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    input  logic [63:0] dadr_i,
    input  logic [63:0] ddat_i,
    input  logic [1:0]  dsiz_i,
    input  logic        dsigned_i,
    output logic [63:0] ddat_o,
    output logic        dack_o,
    output logic        derr_o,
    output logic [63:0] madr_o,
    output logic [63:0] mdat_o,
    output logic        mwe_o,
    output logic        mcyc_o,
    output logic        mstb_o,
    output logic [1:0]  msiz_o,
    output logic        msigned_o,
    input  logic [63:0] mdat_i,
    input  logic        mack_i
);

    state_t r_state;
    state_t w_next;
    logic   r_last_d;
    logic   w_dreq;
    logic   w_expired;
    logic   w_timeout;
    logic   w_clr;
    logic   w_cnt_en;

    assign w_dreq = dcyc_i & dstb_i;

    // Next-state arbitration and AND-OR output muxing; IDLE (and therefore reset) drives all zeros.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        idat_o    = '0;
        iack_o    = 1'b0;
        ierr_o    = 1'b0;
        ddat_o    = '0;
        dack_o    = 1'b0;
        derr_o    = 1'b0;
        madr_o    = '0;
        mdat_o    = '0;
        mwe_o     = 1'b0;
        mcyc_o    = 1'b0;
        mstb_o    = 1'b0;
        msiz_o    = '0;
        msigned_o = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the side that did not go last wins.
                if (w_dreq && (!istb_i || !r_last_d)) begin
                    w_next = DGNT;
                end else if (istb_i) begin
                    w_next = IGNT;
                end
            end
            IGNT: begin
                // An ack in the expiry cycle wins over the timeout.
                w_timeout = w_expired & istb_i & ~mack_i;
                madr_o    = iadr_i;
                msiz_o    = SIZ_WORD;
                mcyc_o    = ~w_timeout;
                mstb_o    = istb_i & ~w_timeout;
                iack_o    = mack_i;
                idat_o    = word_sel(mdat_i, iadr_i[2]);
                ierr_o    = w_timeout;
                // A dropped istb_i abandons the fetch; mack_i is only forwarded while granted.
                if (mack_i || !istb_i || w_timeout) begin
                    w_next = IDLE;
                end
            end
            DGNT: begin
                w_timeout = w_expired & dstb_i & ~mack_i;
                madr_o    = dadr_i;
                mdat_o    = ddat_i;
                mwe_o     = dwe_i;
                msiz_o    = dsiz_i;
                msigned_o = dsigned_i;
                mcyc_o    = dcyc_i & ~w_timeout;
                mstb_o    = dstb_i & ~w_timeout;
                dack_o    = mack_i;
                ddat_o    = mdat_i;
                derr_o    = w_timeout;
                // dcyc_i locks the bus for back-to-back beats; release is decided on dcyc_i alone.
                if (!dcyc_i || w_timeout) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Registered grant state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Remember which side last held the bus, for tie-breaking.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_last_d <= 1'b0;
        end else if ((r_state == IGNT) && (w_next == IDLE)) begin
            r_last_d <= 1'b0;
        end else if ((r_state == DGNT) && (w_next == IDLE)) begin
            r_last_d <= 1'b1;
        end
    end

    // Watchdog restarts on every grant change and every ack; it only counts stalled strobes.
    assign w_clr    = (w_next != r_state) | mack_i;
    assign w_cnt_en = mstb_o & ~mack_i;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) u_wdog (
        .i_clk     (clk_i),
        .i_rst     (reset_i),
        .i_clr     (w_clr),
        .i_cnt_en  (w_cnt_en),
        .o_expired (w_expired)
    );

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Self-checking bench for polaris_bus_arbiter: vector table, directed corner cases, random vs. reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_polaris_bus_arbiter;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        istb_i;
    logic [63:0] iadr_i;
    logic [31:0] idat_o;
    logic        iack_o, ierr_o;
    logic        dcyc_i, dstb_i, dwe_i;
    logic [63:0] dadr_i, ddat_i;
    logic [1:0]  dsiz_i;
    logic        dsigned_i;
    logic [63:0] ddat_o;
    logic        dack_o, derr_o;
    logic [63:0] madr_o, mdat_o;
    logic        mwe_o, mcyc_o, mstb_o;
    logic [1:0]  msiz_o;
    logic        msigned_o;
    logic [63:0] mdat_i;
    logic        mack_i;

    always #5 clk_i = ~clk_i;

    polaris_bus_arbiter #(.TIMEOUT(TO), .CNTW(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .istb_i(istb_i), .iadr_i(iadr_i), .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
        .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i), .dadr_i(dadr_i), .ddat_i(ddat_i),
        .dsiz_i(dsiz_i), .dsigned_i(dsigned_i), .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
        .madr_o(madr_o), .mdat_o(mdat_o), .mwe_o(mwe_o), .mcyc_o(mcyc_o), .mstb_o(mstb_o),
        .msiz_o(msiz_o), .msigned_o(msigned_o), .mdat_i(mdat_i), .mack_i(mack_i)
    );

    typedef struct packed {
        logic [31:0] idat;
        logic        iack;
        logic        ierr;
        logic [63:0] ddat;
        logic        dack;
        logic        derr;
        logic [63:0] madr;
        logic [63:0] mdat;
        logic        mwe;
        logic        mcyc;
        logic        mstb;
        logic [1:0]  msiz;
        logic        msigned;
    } obs_t;

    obs_t got;
    assign got = {idat_o, iack_o, ierr_o, ddat_o, dack_o, derr_o, madr_o, mdat_o,
                  mwe_o, mcyc_o, mstb_o, msiz_o, msigned_o};

    // Control-only vector: inputs and expected {mcyc, mstb, iack, dack, ierr, derr}.
    typedef struct {
        logic       istb;
        logic       dcyc;
        logic       dstb;
        logic       mack;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic i, input logic c, input logic s, input logic a, input logic [5:0] e);
        vec_t v;
        v.istb = i; v.dcyc = c; v.dstb = s; v.mack = a; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_pulse();
        reset_i = 1'b1;
        #2;
        reset_i = 1'b0;
    endtask

    // Reference model: who owns the bus, who went last, how long the current strobe has stalled.
    int m_owner;   // 0 none, 1 instruction, 2 data
    bit m_last_d;
    int m_wait;

    function automatic bit model_strobe();
        if (m_owner == 1) return istb_i;
        if (m_owner == 2) return dstb_i;
        return 1'b0;
    endfunction

    function automatic bit model_expire();
        return (TO != 0) && (m_owner != 0) && model_strobe() && !mack_i && (m_wait >= TO);
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        bit   ex;
        logic [63:0] rd;
        o  = '0;
        ex = model_expire();
        rd = mdat_i;
        if (m_owner == 1) begin
            o.madr = iadr_i;
            o.msiz = 2'd2;
            o.mcyc = !ex;
            o.mstb = istb_i && !ex;
            o.iack = mack_i;
            o.idat = iadr_i[2] ? rd[63:32] : rd[31:0];
            o.ierr = ex;
        end else if (m_owner == 2) begin
            o.madr    = dadr_i;
            o.mdat    = ddat_i;
            o.mwe     = dwe_i;
            o.msiz    = dsiz_i;
            o.msigned = dsigned_i;
            o.mcyc    = dcyc_i && !ex;
            o.mstb    = dstb_i && !ex;
            o.dack    = mack_i;
            o.ddat    = mdat_i;
            o.derr    = ex;
        end
        return o;
    endfunction

    task automatic model_edge();
        bit dreq, done, ex;
        dreq = dcyc_i && dstb_i;
        ex   = model_expire();
        if (m_owner == 0) begin
            if (dreq && istb_i) m_owner = m_last_d ? 1 : 2;
            else if (dreq)      m_owner = 2;
            else if (istb_i)    m_owner = 1;
            m_wait = 0;
        end else begin
            done = ex || ((m_owner == 1) ? (mack_i || !istb_i) : !dcyc_i);
            if (done) begin
                m_last_d = (m_owner == 2);
                m_owner  = 0;
                m_wait   = 0;
            end else if (mack_i) begin
                m_wait = 0;
            end else if (model_strobe()) begin
                m_wait = (m_wait + 1 > TO) ? TO : m_wait + 1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int iacks;
        reset_i = 1'b1; istb_i = 1'b1; dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b1;
        iadr_i = 64'h1004; dadr_i = 64'h2000; ddat_i = 64'h55; dsiz_i = 2'd3; dsigned_i = 1'b1;
        mdat_i = 64'hFFFF_FFFF_FFFF_FFFF; mack_i = 1'b1;

        // Reset held with both masters requesting: everything is quiet.
        @(negedge clk_i);
        check("reset_outputs_a", 256'(got), 256'(0));
        step();
        check("reset_outputs_b", 256'(got), 256'(0));
        reset_i = 1'b0;
        dwe_i = 1'b0; dsiz_i = 2'd0; dsigned_i = 1'b0; mack_i = 1'b0;

        // istb, dcyc, dstb, mack, {mcyc, mstb, iack, dack, ierr, derr}
        add(1,1,1,0, 6'b000000);  // idle, tie with lastD=0 -> D
        add(1,1,1,1, 6'b110100);  // locked beat 1
        add(1,1,1,1, 6'b110100);  // locked beat 2
        add(1,1,1,1, 6'b110100);  // locked beat 3
        add(1,0,0,0, 6'b000000);  // dcyc drops -> release
        add(1,0,0,0, 6'b000000);  // idle, I requests
        add(1,0,0,0, 6'b110000);  // I granted, wait state
        add(1,0,0,1, 6'b111000);  // I ack
        add(1,1,1,0, 6'b000000);  // tie with lastD=0 -> D
        add(1,0,1,1, 6'b010100);  // dcyc drops with ack
        add(1,1,1,0, 6'b000000);  // tie with lastD=1 -> I
        add(1,1,1,0, 6'b110000);  // D waits while I owns bus
        add(0,1,1,0, 6'b100000);  // istb drops: fetch abandoned
        add(0,1,1,0, 6'b000000);  // idle -> D
        repeat (4) add(0,1,1,0, 6'b110000);  // 4 stalled strobes
        add(0,1,1,0, 6'b000001);  // timeout: derr, strobe forced low
        add(0,0,0,0, 6'b000000);
        add(0,1,1,0, 6'b000000);  // idle -> D
        repeat (3) add(0,1,1,0, 6'b110000);
        add(0,1,1,1, 6'b110100);  // ack on 4th strobe cycle: no error
        add(0,0,0,0, 6'b000000);
        add(0,1,1,0, 6'b000000);  // idle -> D
        repeat (4) add(0,1,1,0, 6'b110000);
        add(0,1,1,1, 6'b110100);  // ack coincides with expiry: ack wins
        add(0,0,0,0, 6'b000000);

        foreach (vecs[i]) begin
            istb_i = vecs[i].istb; dcyc_i = vecs[i].dcyc; dstb_i = vecs[i].dstb; mack_i = vecs[i].mack;
            @(negedge clk_i);
            check($sformatf("vec%0d", i),
                  256'({mcyc_o, mstb_o, iack_o, dack_o, ierr_o, derr_o}), 256'(vecs[i].exp));
            step();
        end

        // Instruction fetch from 0x1004 returns the upper word; ack lasts one cycle.
        reset_pulse();
        istb_i = 1'b1; dcyc_i = 1'b0; dstb_i = 1'b0; iadr_i = 64'h1004;
        mdat_i = 64'hAAAA_BBBB_1111_2222; mack_i = 1'b0; iacks = 0;
        for (int k = 0; k < 5; k++) begin
            mack_i = (k == 2);
            if (k > 2) istb_i = 1'b0;
            @(negedge clk_i);
            if (iack_o) iacks++;
            if (k == 0) check("ifetch_no_strobe_idle", 256'(mstb_o), 256'(0));
            if (k == 1) check("ifetch_madr", 256'({madr_o, msiz_o, mstb_o}), 256'({64'h1004, 2'b10, 1'b1}));
            if (k == 2) check("ifetch_idat", 256'({idat_o, iack_o}), 256'({32'hAAAA_BBBB, 1'b1}));
            step();
        end
        check("ifetch_ack_count", 256'(iacks), 256'(1));

        // Data store passes through unchanged until acknowledged.
        istb_i = 1'b0; dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b1;
        dadr_i = 64'h2000; ddat_i = 64'h55; dsiz_i = 2'd0; mdat_i = 64'h1234_5678_9ABC_DEF0;
        for (int k = 0; k < 5; k++) begin
            mack_i = (k == 3);
            if (k == 4) begin dcyc_i = 1'b0; dstb_i = 1'b0; end
            @(negedge clk_i);
            if (k >= 1 && k <= 3)
                check($sformatf("dstore_bus_%0d", k), 256'({madr_o, mwe_o, msiz_o, mdat_o, mstb_o}),
                      256'({64'h2000, 1'b1, 2'b00, 64'h55, 1'b1}));
            if (k == 3) check("dstore_ack", 256'({dack_o, ddat_o}), 256'({1'b1, 64'h1234_5678_9ABC_DEF0}));
            if (k == 4) check("dstore_release", 256'({mcyc_o, mstb_o, dack_o}), 256'(0));
            step();
        end
        dwe_i = 1'b0;

        // Reset in the middle of an instruction grant.
        istb_i = 1'b1; mack_i = 1'b0;
        @(negedge clk_i);
        step();
        @(negedge clk_i);
        check("rst_mid_ignt_before", 256'(mstb_o), 256'(1));
        #1 reset_i = 1'b1;
        #1 check("rst_mid_ignt_strobe", 256'({mcyc_o, mstb_o}), 256'(0));
        mack_i = 1'b1;
        step();
        check("rst_mid_ignt_noack", 256'(got), 256'(0));
        reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_release_noack", 256'(iack_o), 256'(0));
        #1 istb_i = 1'b0; mack_i = 1'b0;
        step();

        // Random traffic against the reference model.
        reset_pulse();
        m_owner = 0; m_last_d = 1'b0; m_wait = 0;
        for (int n = 0; n < 3000; n++) begin
            istb_i    = 1'($urandom_range(0, 1));
            dcyc_i    = dcyc_i ? ($urandom_range(0, 4) != 0) : 1'($urandom_range(0, 1));
            dstb_i    = ($urandom_range(0, 3) != 0);
            dwe_i     = 1'($urandom_range(0, 1));
            dsiz_i    = 2'($urandom_range(0, 3));
            dsigned_i = 1'($urandom_range(0, 1));
            iadr_i    = {$urandom(), $urandom()};
            dadr_i    = {$urandom(), $urandom()};
            ddat_i    = {$urandom(), $urandom()};
            mdat_i    = {$urandom(), $urandom()};
            mack_i    = ($urandom_range(0, 3) == 0);
            @(negedge clk_i);
            check($sformatf("random_cycle_%0d", n), 256'(got), 256'(model_out()));
            model_edge();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
